// File: rtl/rgb2gray_pkg.sv
// Shared widths, default BT.601 weights and pixel channel layout for the RGB-to-grayscale block.
package rgb2gray_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CH_W  = 8;

  localparam int unsigned DEF_COEF_R = 77;
  localparam int unsigned DEF_COEF_G = 150;
  localparam int unsigned DEF_COEF_B = 29;

  localparam int unsigned ROUND_CONST = 128;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb2gray_luma.sv
// Two-stage luma datapath: registered channel products, then registered rounded/saturated sum.
// RGB2GRAY_ROUND_EN selects round-half-up instead of truncation.
module rgb2gray_luma
  import rgb2gray_pkg::*;
#(
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  rgb_t            i_pix,
  output logic [CH_W-1:0] o_y
);

`ifdef RGB2GRAY_ROUND_EN
  localparam logic [16:0] RND = 17'(ROUND_CONST);
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  logic [15:0]     r_prod_r;
  logic [15:0]     r_prod_g;
  logic [15:0]     r_prod_b;
  logic [16:0]     w_sum;
  logic [CH_W-1:0] w_y;
  logic [CH_W-1:0] r_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
      r_y      <= '0;
    end else if (i_en) begin
      r_prod_r <= 16'(i_pix.r) * 16'(COEF_R);
      r_prod_g <= 16'(i_pix.g) * 16'(COEF_G);
      r_prod_b <= 16'(i_pix.b) * 16'(COEF_B);
      r_y      <= w_y;
    end
  end

  assign w_sum = {1'b0, r_prod_r} + {1'b0, r_prod_g} + {1'b0, r_prod_b} + RND;
  // Bit 16 set means the shifted result exceeds 8 bits; clamp rather than wrap.
  assign w_y   = w_sum[16] ? {CH_W{1'b1}} : w_sum[15:8];
  assign o_y   = r_y;

endmodule

// File: rtl/demo_rgb_to_grayscale_design_source.sv
// AXI4-Stream RGB-to-grayscale converter: handshake, valid bits and TLAST/TUSER pipeline.
// Rounding mode is selected by RGB2GRAY_ROUND_EN (see rgb2gray_luma).
module demo_rgb_to_grayscale_design_source
  import rgb2gray_pkg::*;
#(
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_axis_tvalid,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic             m_axis_tvalid,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready
);

  if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_check
    $error("rgb2gray: COEF_R + COEF_G + COEF_B must equal 256");
  end

  logic            w_en;
  logic [CH_W-1:0] w_y;
  logic            r_v1;
  logic            r_last1;
  logic            r_user1;
  logic            r_v2;
  logic            r_last2;
  logic            r_user2;

  // Whole pipeline advances together; only a stalled valid output blocks it.
  assign w_en = m_axis_tready | ~r_v2;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_user1 <= 1'b0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_user2 <= 1'b0;
    end else if (w_en) begin
      r_v1    <= s_axis_tvalid;
      r_last1 <= s_axis_tvalid & s_axis_tlast;
      r_user1 <= s_axis_tvalid & s_axis_tuser;
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      r_user2 <= r_user1;
    end
  end

  rgb2gray_luma #(
    .COEF_R (COEF_R),
    .COEF_G (COEF_G),
    .COEF_B (COEF_B)
  ) u_luma (
    .i_clk (aclk),
    .i_rst (areset),
    .i_en  (w_en),
    .i_pix (rgb_t'(s_axis_tdata)),
    .o_y   (w_y)
  );

  assign s_axis_tready = w_en & ~areset;
  assign m_axis_tvalid = r_v2;
  assign m_axis_tdata  = {w_y, w_y, w_y};
  assign m_axis_tlast  = r_last2;
  assign m_axis_tuser  = r_user2;

endmodule

// File: tb/tb_demo_rgb_to_grayscale_design_source.sv
// Directed self-checking bench for the RGB-to-grayscale converter (both rounding builds).
`timescale 1ns/1ps
module tb_demo_rgb_to_grayscale_design_source;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned FRAME_H = 8;

`ifdef RGB2GRAY_ROUND_EN
  localparam int unsigned RND   = 128;
  localparam logic [23:0] EXP_R = 24'h4D4D4D;
  localparam logic [23:0] EXP_B = 24'h1D1D1D;
`else
  localparam int unsigned RND   = 0;
  localparam logic [23:0] EXP_R = 24'h4C4C4C;
  localparam logic [23:0] EXP_B = 24'h1C1C1C;
`endif

  localparam logic [23:0] PIN [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
  localparam logic [23:0] PEXP[5] = '{24'hFFFFFF, 24'h000000, EXP_R, 24'h959595, EXP_B};

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [23:0] m_tdata;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready = 1'b1;

  int total = 0;
  int bad = 0;
  logic [25:0] q_exp[$];

  always #5 aclk = ~aclk;

  demo_rgb_to_grayscale_design_source dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready)
  );

  function automatic logic [7:0] ref_y(input logic [23:0] p);
    int unsigned s;
    s = 32'(p[23:16]) * 77 + 32'(p[15:8]) * 150 + 32'(p[7:0]) * 29 + RND;
    s = s >> 8;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic logic [23:0] pix(input int i);
    return {8'(i * 7 + 3), 8'(i * 13 + 5), 8'(i * 29 + 11)};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 24'hFFFFFF; s_tlast = 1'b1; s_tuser = 1'b1;
    step(); step(); #2;
    total++;
    if ({m_tvalid, m_tlast, m_tuser} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got v/l/u=%b want 000", {m_tvalid, m_tlast, m_tuser});
    end
    total++;
    if (m_tdata !== 24'h0) begin
      bad++; $display("FAIL reset_tdata: got %h want 000000", m_tdata);
    end
    total++;
    if (s_tready !== 1'b0) begin
      bad++; $display("FAIL reset_tready: got %b want 0", s_tready);
    end
    areset = 1'b0; idle_inputs();
    step();
    m_tready = 1'b0; #2;
    total++;
    if (s_tready !== 1'b1) begin
      bad++; $display("FAIL empty_tready: got %b want 1", s_tready);
    end
    m_tready = 1'b1;
    step();
  endtask

  task automatic test_primaries();
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (i < 5) begin
        s_tvalid = 1'b1; s_tdata = PIN[i]; s_tuser = (i == 0); s_tlast = (i == 4);
      end
      #2;
      if (i >= 2) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== PEXP[i-2] || m_tuser !== (i == 2)
            || m_tlast !== (i == 6)) begin
          bad++;
          $display("FAIL primary_%0d: got v=%b d=%h l=%b u=%b want v=1 d=%h l=%b u=%b",
                   i - 2, m_tvalid, m_tdata, m_tlast, m_tuser, PEXP[i-2], (i == 6), (i == 2));
        end
      end
      step();
    end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_frame();
    int n;
    int sent;
    int got;
    int cyc;
    int first_acc;
    int first_pop;
    logic [25:0] e;
    n = FRAME_W * FRAME_H; sent = 0; got = 0; cyc = 0; first_acc = -1; first_pop = -1;
    q_exp.delete(); m_tready = 1'b1;
    while (got < n && cyc < n + 50) begin
      idle_inputs();
      if (sent < n) begin
        s_tvalid = 1'b1; s_tdata = pix(sent);
        s_tuser = (sent == 0); s_tlast = (sent % FRAME_W == FRAME_W - 1);
      end
      #2;
      if (m_tvalid && m_tready) begin
        if (first_pop < 0) first_pop = cyc;
        total++;
        if (q_exp.size() == 0) begin
          bad++; $display("FAIL frame_extra: got beat %h with nothing expected", m_tdata);
        end else begin
          e = q_exp.pop_front();
          if ({m_tlast, m_tuser, m_tdata} !== e) begin
            bad++;
            $display("FAIL frame_beat_%0d: got l/u/d=%b/%b/%h want %b/%b/%h",
                     got, m_tlast, m_tuser, m_tdata, e[25], e[24], e[23:0]);
          end
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        if (first_acc < 0) first_acc = cyc;
        q_exp.push_back({s_tlast, s_tuser, {3{ref_y(s_tdata)}}});
        sent++;
      end
      step(); cyc++;
    end
    total++;
    if (got != n) begin
      bad++; $display("FAIL frame_count: got %0d beats want %0d", got, n);
    end
    total++;
    if (first_pop - first_acc != 2) begin
      bad++; $display("FAIL frame_latency: got %0d cycles want 2", first_pop - first_acc);
    end
    total++;
    if (cyc != n + 2) begin
      bad++; $display("FAIL frame_throughput: got %0d cycles want %0d", cyc, n + 2);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    int n;
    int sent;
    int got;
    int cyc;
    logic [25:0] e;
    logic [25:0] held;
    n = 20; sent = 0; got = 0; cyc = 0; held = '0;
    q_exp.delete();
    while (got < n && cyc < n + 50) begin
      idle_inputs();
      m_tready = !(cyc >= 8 && cyc <= 12);
      if (sent < n) begin
        s_tvalid = 1'b1; s_tdata = pix(500 + sent);
        s_tuser = (sent == 0); s_tlast = (sent % 4 == 3);
      end
      #2;
      if (cyc == 8) held = {m_tlast, m_tuser, m_tdata};
      if (cyc >= 8 && cyc <= 12) begin
        total++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tuser, m_tdata} !== held || s_tready !== 1'b0) begin
          bad++;
          $display("FAIL bp_hold_%0d: got v=%b lud=%h rdy=%b want v=1 lud=%h rdy=0",
                   cyc, m_tvalid, {m_tlast, m_tuser, m_tdata}, s_tready, held);
        end
      end
      if (m_tvalid && m_tready) begin
        total++;
        if (q_exp.size() == 0) begin
          bad++; $display("FAIL bp_extra: got beat %h with nothing expected", m_tdata);
        end else begin
          e = q_exp.pop_front();
          if ({m_tlast, m_tuser, m_tdata} !== e) begin
            bad++;
            $display("FAIL bp_beat_%0d: got lud=%h want %h", got, {m_tlast, m_tuser, m_tdata}, e);
          end
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        q_exp.push_back({s_tlast, s_tuser, {3{ref_y(s_tdata)}}});
        sent++;
      end
      step(); cyc++;
    end
    total++;
    if (got != n || q_exp.size() != 0) begin
      bad++; $display("FAIL bp_count: got %0d beats, %0d left want %0d, 0", got, q_exp.size(), n);
    end
    m_tready = 1'b1; idle_inputs();
    step();
  endtask

  task automatic test_bubbles();
    logic        ev;
    logic [23:0] ed;
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (i < 4 && i % 2 == 0) begin
        s_tvalid = 1'b1; s_tdata = pix(100 + i); s_tuser = (i == 0); s_tlast = (i == 2);
      end else begin
        s_tdata = 24'hABCDEF; s_tlast = 1'b1; s_tuser = 1'b1;
      end
      #2;
      ev = (i >= 2) && (i - 2 < 4) && ((i - 2) % 2 == 0);
      ed = {3{ref_y(pix(100 + i - 2))}};
      total++;
      if (m_tvalid !== ev) begin
        bad++; $display("FAIL bubble_valid_%0d: got %b want %b", i, m_tvalid, ev);
      end
      total++;
      if (ev) begin
        if (m_tdata !== ed || m_tuser !== (i == 2) || m_tlast !== (i == 4)) begin
          bad++;
          $display("FAIL bubble_data_%0d: got d=%h l=%b u=%b want d=%h l=%b u=%b",
                   i, m_tdata, m_tlast, m_tuser, ed, (i == 4), (i == 2));
        end
      end else if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
        bad++; $display("FAIL bubble_side_%0d: got l=%b u=%b want 0 0", i, m_tlast, m_tuser);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = pix(200); s_tlast = 1'b1; s_tuser = 1'b1;
    #2; step();
    s_tdata = pix(201); s_tlast = 1'b0; s_tuser = 1'b0;
    #2;
    total++;
    if (s_tready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_accept: got tready=%b want 1", s_tready);
    end
    step();
    idle_inputs(); areset = 1'b1;
    #2;
    total++;
    if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_inflight: got v=%b rdy=%b want v=1 rdy=0", m_tvalid, s_tready);
    end
    step();
    areset = 1'b0; m_tready = 1'b1;
    #2;
    total++;
    if ({m_tvalid, m_tlast, m_tuser} !== 3'b000 || m_tdata !== 24'h0) begin
      bad++;
      $display("FAIL rst_mid_clear: got vlu=%b d=%h want 000 000000",
               {m_tvalid, m_tlast, m_tuser}, m_tdata);
    end
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      total++;
      if (m_tvalid !== 1'b0) begin
        bad++; $display("FAIL rst_mid_flush_%0d: got v=%b want 0", i, m_tvalid);
      end
    end
    step();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 3) begin
        s_tvalid = 1'b1; s_tdata = pix(300 + i); s_tuser = (i == 0); s_tlast = (i == 2);
      end
      #2;
      if (i >= 2) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== {3{ref_y(pix(300 + i - 2))}}
            || m_tuser !== (i == 2) || m_tlast !== (i == 4)) begin
          bad++;
          $display("FAIL rst_mid_next_%0d: got v=%b d=%h l=%b u=%b want v=1 d=%h l=%b u=%b",
                   i - 2, m_tvalid, m_tdata, m_tlast, m_tuser, {3{ref_y(pix(300 + i - 2))}},
                   (i == 4), (i == 2));
        end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_primaries();
    test_frame();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
